// File: rtl/qm_pkg.sv
// Shared types and width helpers for the multi-port queue manager.
package qm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A descriptor is {len[AW:0], start[AW-1:0]}.
  function automatic int unsigned desc_w(input int unsigned aw);
    return 2 * aw + 1;
  endfunction

endpackage

// File: rtl/qm_ptr_fifo.sv
// Show-ahead synchronous FIFO holding frame descriptors for one port.
module qm_ptr_fifo
  import qm_pkg::*;
#(
  parameter int W     = 17,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [W-1:0]              din,
  input  logic                      pop,
  output logic [W-1:0]              dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/qm_mp.sv
// Multi-port queue manager: steers ingress frames into per-port circular
// regions of one RAM and hands out {len, start} descriptors per port.
module qm_mp
  import qm_pkg::*;
#(
  parameter int DW        = 8,
  parameter int NPORT     = 4,
  parameter int DEPTH     = 256,
  parameter int PTR_DEPTH = 16,
  parameter int MAX_LEN   = 64,
  localparam int AW       = idx_w(DEPTH),
  localparam int PW       = idx_w(NPORT),
  localparam int DESC_W   = desc_w(AW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PW-1:0]     port_id,
  input  logic              sof,
  input  logic              dv,
  input  logic [DW-1:0]     data,
  output logic [NPORT-1:0]  bp,
  input  logic [PW-1:0]     rd_port,
  input  logic              ptr_fifo_rd,
  output logic [DESC_W-1:0] ptr_fifo_dout,
  output logic [NPORT-1:0]  ptr_empty,
  input  logic              data_fifo_rd,
  output logic [DW-1:0]     data_fifo_dout,
  output logic [15:0]       drop_cnt
);

  localparam int CW               = $clog2(PTR_DEPTH) + 1;
  localparam logic [AW:0] LEN_ONE = (AW + 1)'(1);
  localparam logic [AW:0] MAX_LW  = (AW + 1)'(MAX_LEN);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  state_t        state, state_nx;
  logic [PW-1:0] cur_port, cur_port_nx;
  logic [AW-1:0] start, start_nx;
  logic [AW:0]   len, len_nx;

  logic [AW-1:0] wr_ptr    [NPORT];
  logic [AW-1:0] wr_ptr_nx [NPORT];
  logic [AW-1:0] rd_ptr    [NPORT];
  logic [AW:0]   free      [NPORT];
  logic [AW:0]   free_nx   [NPORT];
  logic [DW-1:0] mem       [NPORT*DEPTH];

  logic [NPORT-1:0]  fifo_full;
  logic [NPORT-1:0]  fifo_empty;
  logic [NPORT-1:0]  fifo_push;
  logic [NPORT-1:0]  fifo_pop;
  logic [DESC_W-1:0] fifo_dout  [NPORT];
  logic [CW-1:0]     fifo_count [NPORT];

  logic          wr_en;
  logic [PW-1:0] wr_port;
  logic [AW-1:0] wr_addr;
  logic          rollback;
  logic          commit_ok;
  logic          drop_inc;
  logic          sof_start;
  logic [AW-1:0] new_base;
  logic          rd_ok;

  assign rd_ok = data_fifo_rd && (free[rd_port] != DEPTH_W);

  // A frame that ends (or is cut short by a new sof) commits or rolls back
  // first; a new frame on the same port then starts at the rolled-back pointer.
  always_comb begin
    state_nx    = state;
    cur_port_nx = cur_port;
    start_nx    = start;
    len_nx      = len;
    wr_en       = 1'b0;
    wr_port     = cur_port;
    wr_addr     = wr_ptr[cur_port];
    rollback    = 1'b0;
    commit_ok   = 1'b0;
    drop_inc    = 1'b0;
    sof_start   = 1'b0;
    new_base    = wr_ptr[port_id];

    case (state)
      IDLE: begin
        if (dv && sof) sof_start = 1'b1;
      end
      RECV: begin
        if (!dv || sof) begin
          if (fifo_full[cur_port]) begin
            rollback = 1'b1;
            drop_inc = 1'b1;
          end else begin
            commit_ok = 1'b1;
          end
          state_nx = IDLE;
          if (dv) sof_start = 1'b1;
        end else if (len == MAX_LW || free[cur_port] == '0) begin
          rollback = 1'b1;
          drop_inc = 1'b1;
          state_nx = DROP;
        end else begin
          wr_en  = 1'b1;
          len_nx = len + LEN_ONE;
        end
      end
      DROP: begin
        if (dv && sof)  sof_start = 1'b1;
        else if (!dv)   state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (sof_start) begin
      new_base    = (rollback && port_id == cur_port) ? start : wr_ptr[port_id];
      wr_en       = 1'b1;
      wr_port     = port_id;
      wr_addr     = new_base;
      cur_port_nx = port_id;
      start_nx    = new_base;
      len_nx      = LEN_ONE;
      state_nx    = RECV;
    end
  end

  // Rollback returns every word of the frame to free space, so reads that
  // happened meanwhile stay accounted for.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      wr_ptr_nx[p] = wr_ptr[p];
      free_nx[p]   = free[p];
      if (rollback && cur_port == PW'(p)) begin
        wr_ptr_nx[p] = start;
        free_nx[p]   = free_nx[p] + len;
      end
      if (wr_en && wr_port == PW'(p)) begin
        wr_ptr_nx[p] = wr_addr + AW'(1);
        free_nx[p]   = free_nx[p] - LEN_ONE;
      end
      if (rd_ok && rd_port == PW'(p)) free_nx[p] = free_nx[p] + LEN_ONE;
      fifo_push[p] = commit_ok && (cur_port == PW'(p));
      fifo_pop[p]  = ptr_fifo_rd && (rd_port == PW'(p));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_port <= '0;
      start    <= '0;
      len      <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nx;
      cur_port <= cur_port_nx;
      start    <= start_nx;
      len      <= len_nx;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (rst) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        free[p]   <= DEPTH_W;
        bp[p]     <= 1'b0;
      end else begin
        wr_ptr[p] <= wr_ptr_nx[p];
        free[p]   <= free_nx[p];
        if (rd_ok && rd_port == PW'(p)) rd_ptr[p] <= rd_ptr[p] + AW'(1);
        bp[p] <= (free[p] < MAX_LW) || (fifo_count[p] >= CW'(PTR_DEPTH - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_port, wr_addr}] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst)        data_fifo_dout <= '0;
    else if (rd_ok) data_fifo_dout <= mem[{rd_port, rd_ptr[rd_port]}];
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_fifo
    qm_ptr_fifo #(
      .W     (DESC_W),
      .DEPTH (PTR_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[p]),
      .din   ({len, start}),
      .pop   (fifo_pop[p]),
      .dout  (fifo_dout[p]),
      .full  (fifo_full[p]),
      .empty (fifo_empty[p]),
      .count (fifo_count[p])
    );
  end

  assign ptr_fifo_dout = fifo_dout[rd_port];
  assign ptr_empty     = fifo_empty;

endmodule

// File: doc/qm_mp.md
Name: qm_mp

Overview:
- Multi-port successor to the single-queue manager. Ingress frames marked by sof/dv are steered by port_id into per-port circular regions of one shared data RAM.
- On frame completion, one descriptor {len, start} is pushed into that port's pointer FIFO.
- The egress scheduler selects a port, pops its descriptor, then reads the frame bytes.
- Adds per-port backpressure, oversize/overflow frame drop with write-pointer rollback, and a drop counter.

Parameters:
- DW, 8, data byte/word width
- NPORT, 4, number of output queues (power of 2, ≥2)
- DEPTH, 256, data words per port region (power of 2); AW = log2(DEPTH)
- PTR_DEPTH, 16, descriptors per port pointer FIFO (power of 2)
- MAX_LEN, 64, maximum accepted frame length in words (≤DEPTH)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- port_id  in  log2(NPORT)  destination queue; sampled on the sof cycle only
- sof  in  1  first word of frame; valid only with dv=1
- dv  in  1  data valid; held high for the whole frame; frame ends on the first dv=0 cycle
- data  in  DW  ingress word
- bp  out  NPORT  per-port backpressure, registered; source must not start a frame to port p while bp[p]=1
- rd_port  in  log2(NPORT)  egress port select for both read strobes
- ptr_fifo_rd  in  1  pop the head descriptor of rd_port
- ptr_fifo_dout  out  2*AW+1  head descriptor of rd_port, show-ahead: {len[AW:0], start[AW-1:0]}
- ptr_empty  out  NPORT  per-port descriptor FIFO empty
- data_fifo_rd  in  1  read one word from rd_port region
- data_fifo_dout  out  DW  read data, registered, valid 1 cycle after data_fifo_rd
- drop_cnt  out  16  dropped-frame counter, saturating

Behaviour:
- Reset (applied on a clk edge with rst=1):
  - All wr/rd pointers = 0; free[p] = DEPTH; ptr FIFOs empty; ptr_empty = all 1s.
  - bp = 0; data_fifo_dout = 0; drop_cnt = 0; FSM = IDLE.
  - Reset mid-frame discards the partial frame; no descriptor is pushed.
- Ingress FSM states: IDLE, RECV, DROP.
  - IDLE + dv&sof:
    - Latch port P and start = wr_ptr[P].
    - Write the word at {P, wr_ptr[P]}; len = 1; go to RECV.
  - IDLE + dv without sof: word ignored; stay in IDLE.
  - RECV + dv&~sof:
    - If len == MAX_LEN or free[P] == 0: roll back wr_ptr[P] to start, restore free[P], drop_cnt++, go to DROP.
    - Otherwise write the word; len++; wr_ptr[P] wraps modulo DEPTH.
  - RECV + ~dv:
    - Commit: push {len, start} to ptr FIFO P; go to IDLE.
    - Descriptor is visible on ptr_fifo_dout (ptr_empty[P] = 0) the next cycle.
  - RECV + dv&sof (back-to-back frames, no gap):
    - Commit the current frame and start a new frame in the same cycle, with the new port_id.
  - DROP: discard words until ~dv, then go to IDLE. dv&sof in DROP starts a new frame as in IDLE.
  - Commit when ptr FIFO P is full: frame dropped (rollback, drop_cnt++). This is a protocol violation given bp.
- Free space:
  - free[p] is decremented per written word and incremented per data_fifo_rd on p.
  - Simultaneous write and read on the same port: net change is 0.
  - On rollback, the free count includes any reads that occurred during the frame.
- Backpressure: bp[p] <= (free[p] < MAX_LEN) | (ptr FIFO p count ≥ PTR_DEPTH-1).
  - bp has one-cycle latency.
  - A frame already in progress is never blocked by bp.
- Egress reads:
  - ptr_fifo_rd on an empty port is ignored.
  - data_fifo_rd reads {rd_port, rd_ptr[rd_port]}; data_fifo_dout is registered next cycle; rd_ptr wraps modulo DEPTH.
  - data_fifo_rd when free[rd_port] == DEPTH is ignored, and data_fifo_dout holds its value.
  - Reading bytes of an uncommitted frame is the consumer's error; no protection is provided.
  - Ingress and egress on the same port in the same cycle are legal. The RAM is simple dual-port; the read and write addresses never collide for committed data.
- Width rules:
  - len is AW+1 bits so that a frame of length DEPTH is representable.
  - drop_cnt saturates at 16'hFFFF.

Decomposition:
- Package qm_pkg:
  - state enum {IDLE, RECV, DROP}
  - desc_t packing function / width constant 2*AW+1
  - clog2-based AW and port-index width helpers
- Sub-module qm_ptr_fifo:
  - Synchronous show-ahead FIFO, parametrised width/depth, with full/empty/count outputs.
  - qm_mp instantiates it NPORT times.
- Data RAM is inferred inline.

Test Plan:
- Reset, then a 34-word frame to port 1: sof with 0x01, then 0x32, then 0x02..0x21 with dv held.
  -> One cycle after dv falls: ptr_empty = 4'b1101, descriptor {len=34, start=0}.
  -> 34 data_fifo_rd on rd_port=1 return the same sequence, each 1 cycle after its strobe; drop_cnt = 0.
- Back-to-back: a 10-word frame to port 0, then sof in the cycle after its last word with port_id=2, 5 words.
  -> Port 0 gets descriptor {10, 0}; port 2 gets {5, 0}; no gap needed.
- Oversize: a 70-word frame to port 3 (MAX_LEN=64).
  -> No descriptor; wr_ptr[3] rolled back to 0; drop_cnt = 1.
  -> The following 4-word frame to port 3 gets {4, 0}.
- Backpressure: push 15 one-word frames to port 0 without reading.
  -> bp[0] = 1 one cycle after the 15th commit; other bp bits stay 0.
  -> After one ptr_fifo_rd on port 0, bp[0] returns to 0.
- Wrap: fill port 2 with four 60-word frames, then read all four; then send a 40-word frame.
  -> Descriptor {40, start=240}; readback crosses address 255→0 correctly.
- Mid-frame reset during a 20-word frame.
  -> All ptr_empty = 1, bp = 0, drop_cnt = 0.
  -> A subsequent frame starts at start = 0.
